// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop sync, 3-sample majority vote, framing/parity/overrun flags.
// Define UART_RX_CFG_BREAK_EN to add break_det and suppress delivery of all-zero frames.
module uart_rx_cfg #(
   parameter int MAIN_CLK  = 100000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
`ifdef UART_RX_CFG_BREAK_EN
   ,
   output logic                 break_det
`endif
);

   localparam int BAUD_DIVIDE = MAIN_CLK / BAUD;
   localparam int MID         = BAUD_DIVIDE / 2;
   localparam int DW          = $clog2(BAUD_DIVIDE);
   localparam int CW          = $clog2(DATA_BITS);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [DW-1:0]        div_q, div_d;
   logic                 s0_q, s0_d, s1_q, s1_d;
   logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 perr_q, perr_d, ferr_q, ferr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
   logic                 overrun_q, overrun_d;
   logic                 rx_s, fall, bit_tick, bit_val, last_stop;
   logic                 frame_done, frame_ferr, deliver;
`ifdef UART_RX_CFG_BREAK_EN
   logic                 zero_q, zero_d, break_q, break_d;
`endif

   assign rx_s      = sync2_q;
   assign fall      = prev_q & ~sync2_q;
   assign bit_tick  = (state_q != S_IDLE) && (div_q == DW'(MID + 1));
   assign bit_val   = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
   assign last_stop = (STOP_BITS == 1) || stop_cnt_q;

   // Bit timing and frame sequencing; each bit is decided on its third sample.
   always_comb begin
      sync1_d    = rx;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      state_d    = state_q;
      div_d      = div_q;
      s0_d       = s0_q;
      s1_d       = s1_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shreg_d    = shreg_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      frame_done = 1'b0;
      frame_ferr = ferr_q;
`ifdef UART_RX_CFG_BREAK_EN
      zero_d     = zero_q;
`endif
      if (state_q == S_IDLE) begin
         div_d = '0;
         if (fall) state_d = S_START;
      end else begin
         div_d = (div_q == DW'(BAUD_DIVIDE - 1)) ? '0 : div_q + DW'(1);
         if (div_q == DW'(MID - 1)) s0_d = rx_s;
         if (div_q == DW'(MID))     s1_d = rx_s;
      end
      if (bit_tick) begin
`ifdef UART_RX_CFG_BREAK_EN
         if (bit_val) zero_d = 1'b0;
`endif
         case (state_q)
            S_START: begin
               if (!bit_val) begin
                  state_d    = S_DATA;
                  bit_cnt_d  = '0;
                  stop_cnt_d = 1'b0;
                  perr_d     = 1'b0;
                  ferr_d     = 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
                  zero_d     = 1'b1;
`endif
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_DATA: begin
               shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
               if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
            S_PARITY: begin
               // Odd parity wants an odd count of ones across data plus parity bit.
               perr_d  = ((^shreg_q) ^ bit_val) != (PARITY == 1);
               state_d = S_STOP;
            end
            S_STOP: begin
               if (!bit_val) ferr_d = 1'b1;
               if (last_stop) begin
                  state_d    = S_IDLE;
                  frame_done = 1'b1;
                  frame_ferr = ferr_q | ~bit_val;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Single-entry output register; a finished frame is dropped while an unaccepted word is held.
   always_comb begin
      data_d       = data_q;
      valid_d      = valid_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
      break_d      = frame_done & zero_q & ~bit_val;
      deliver      = frame_done & ~break_d;
`else
      deliver      = frame_done;
`endif
      if (deliver) begin
         if (!valid_q || data_ready) begin
            data_d       = shreg_q;
            valid_d      = 1'b1;
            frame_err_d  = frame_ferr;
            parity_err_d = perr_q;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         prev_q       <= 1'b1;
         state_q      <= S_IDLE;
         div_q        <= '0;
         s0_q         <= 1'b0;
         s1_q         <= 1'b0;
         bit_cnt_q    <= '0;
         stop_cnt_q   <= 1'b0;
         shreg_q      <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
         zero_q       <= 1'b0;
         break_q      <= 1'b0;
`endif
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         prev_q       <= prev_d;
         state_q      <= state_d;
         div_q        <= div_d;
         s0_q         <= s0_d;
         s1_q         <= s1_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         shreg_q      <= shreg_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_CFG_BREAK_EN
         zero_q       <= zero_d;
         break_q      <= break_d;
`endif
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
`ifdef UART_RX_CFG_BREAK_EN
   assign break_det  = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clocks per bit,
// scoreboarded against expected words queued as each frame is driven.
module tb_uart_rx_cfg;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } word_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_a, rx_b, rx_c;
   logic       ready_a, ready_b, ready_c;
   logic [7:0] data_a, data_c;
   logic [6:0] data_b;
   logic       valid_a, valid_b, valid_c;
   logic       fe_a, fe_b, fe_c, pe_a, pe_b, pe_c;
   logic       ovr_a, ovr_b, ovr_c;
`ifdef UART_RX_CFG_BREAK_EN
   logic       brk_a, brk_b, brk_c;
`endif

   int    checks = 0;
   int    failures = 0;
   word_t exp_a[$], exp_b[$], exp_c[$];
   word_t obs_a[$], obs_b[$], obs_c[$];
   int    rd_a = 0, rd_b = 0, rd_c = 0;
   int    ovr_cnt_a = 0;
   int    brk_cnt_a = 0;

   always #5 clk = ~clk;

   uart_rx_cfg #(.MAIN_CLK(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_a), .data(data_a), .data_valid(valid_a),
      .data_ready(ready_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a)
`ifdef UART_RX_CFG_BREAK_EN
      , .break_det(brk_a)
`endif
   );

   uart_rx_cfg #(.MAIN_CLK(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_b), .data(data_b), .data_valid(valid_b),
      .data_ready(ready_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b)
`ifdef UART_RX_CFG_BREAK_EN
      , .break_det(brk_b)
`endif
   );

   uart_rx_cfg #(.MAIN_CLK(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
      .clk(clk), .rst_n(rst_n), .rx(rx_c), .data(data_c), .data_valid(valid_c),
      .data_ready(ready_c), .frame_err(fe_c), .parity_err(pe_c), .overrun(ovr_c)
`ifdef UART_RX_CFG_BREAK_EN
      , .break_det(brk_c)
`endif
   );

   // Capture every accepted word and count single-cycle pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_a && ready_a) obs_a.push_back({data_a, fe_a, pe_a});
         if (valid_b && ready_b) obs_b.push_back({1'b0, data_b, fe_b, pe_b});
         if (valid_c && ready_c) obs_c.push_back({data_c, fe_c, pe_c});
         if (ovr_a) ovr_cnt_a++;
`ifdef UART_RX_CFG_BREAK_EN
         if (brk_a) brk_cnt_a++;
`endif
      end
   end

   task automatic set_rx(input int which, input logic v);
      case (which)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   task automatic hold(input int which, input logic v, input int clocks);
      set_rx(which, v);
      repeat (clocks) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input int nbits,
                             input bit has_par, input logic pbit,
                             input logic stop1, input logic stop2, input int nstops);
      hold(which, 1'b0, 16);
      for (int i = 0; i < nbits; i++) hold(which, d[i], 16);
      if (has_par) hold(which, pbit, 16);
      hold(which, stop1, 16);
      if (nstops == 2) hold(which, stop2, 16);
      hold(which, 1'b1, 16);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
      ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({data_a, valid_a, fe_a, pe_a, ovr_a} !== 12'h000) begin
         failures++;
         $display("[TB] FAIL reset_a: got %h expected 000", {data_a, valid_a, fe_a, pe_a, ovr_a});
      end
      checks++;
      if ({data_b, valid_b, data_c, valid_c} !== 17'h0) begin
         failures++;
         $display("[TB] FAIL reset_bc: got %h expected 0", {data_b, valid_b, data_c, valid_c});
      end
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if ({valid_a, valid_b, valid_c} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL idle_after_reset: got %b expected 000", {valid_a, valid_b, valid_c});
      end
   endtask

   task automatic test_basic();
      logic [7:0] pats [4] = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
      word_t e, o;
      for (int i = 0; i < 4; i++) begin
         exp_a.push_back({pats[i], 1'b0, 1'b0});
         send_frame(0, pats[i], 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      end
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (obs_a.size() - rd_a != 4) begin
         failures++;
         $display("[TB] FAIL basic_count: got %0d expected 4", obs_a.size() - rd_a);
      end
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front();
         checks++;
         if (rd_a >= obs_a.size()) begin
            failures++;
            $display("[TB] FAIL basic_word: got none expected %h", e);
         end else begin
            o = obs_a[rd_a];
            rd_a++;
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL basic_word: got %h expected %h", o, e);
            end
         end
      end
   endtask

   task automatic test_parity();
      logic [7:0] pd [4] = '{8'h41, 8'h41, 8'h43, 8'h43};
      logic       pb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      word_t e, o;
      for (int i = 0; i < 4; i++) begin
         exp_b.push_back({pd[i], 1'b0, pb[i] != (^pd[i][6:0])});
         send_frame(1, pd[i], 7, 1'b1, pb[i], 1'b1, 1'b1, 1);
      end
      repeat (8) @(posedge clk);
      #1;
      while (exp_b.size() > 0) begin
         e = exp_b.pop_front();
         checks++;
         if (rd_b >= obs_b.size()) begin
            failures++;
            $display("[TB] FAIL parity_word: got none expected %h", e);
         end else begin
            o = obs_b[rd_b];
            rd_b++;
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL parity_word: got %h expected %h", o, e);
            end
         end
      end
   endtask

   task automatic test_stop_bits();
      logic [7:0] sd [3] = '{8'h55, 8'h3C, 8'hA0};
      logic       s1 [3] = '{1'b1, 1'b1, 1'b0};
      logic       s2 [3] = '{1'b0, 1'b1, 1'b1};
      word_t e, o;
      for (int i = 0; i < 3; i++) begin
         exp_c.push_back({sd[i], ~(s1[i] & s2[i]), 1'b0});
         send_frame(2, sd[i], 8, 1'b0, 1'b0, s1[i], s2[i], 2);
      end
      repeat (8) @(posedge clk);
      #1;
      while (exp_c.size() > 0) begin
         e = exp_c.pop_front();
         checks++;
         if (rd_c >= obs_c.size()) begin
            failures++;
            $display("[TB] FAIL stop_word: got none expected %h", e);
         end else begin
            o = obs_c[rd_c];
            rd_c++;
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL stop_word: got %h expected %h", o, e);
            end
         end
      end
   endtask

   task automatic test_overrun();
      int    base;
      word_t e, o;
      base = ovr_cnt_a;
      ready_a = 1'b0;
      exp_a.push_back({8'h11, 1'b0, 1'b0});
      send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      send_frame(0, 8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      checks++;
      if ({valid_a, data_a} !== {1'b1, 8'h11}) begin
         failures++;
         $display("[TB] FAIL overrun_hold: got %h expected 111", {valid_a, data_a});
      end
      checks++;
      if (ovr_cnt_a - base != 1) begin
         failures++;
         $display("[TB] FAIL overrun_pulse: got %0d cycles expected 1", ovr_cnt_a - base);
      end
      ready_a = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (valid_a !== 1'b0) begin
         failures++;
         $display("[TB] FAIL overrun_release: got %b expected 0", valid_a);
      end
      e = exp_a.pop_front();
      checks++;
      if (rd_a >= obs_a.size()) begin
         failures++;
         $display("[TB] FAIL overrun_word: got none expected %h", e);
      end else begin
         o = obs_a[rd_a];
         rd_a++;
         if (o !== e) begin
            failures++;
            $display("[TB] FAIL overrun_word: got %h expected %h", o, e);
         end
      end
   endtask

   task automatic test_glitch();
      word_t e, o;
      hold(0, 1'b0, 4);
      hold(0, 1'b1, 48);
      checks++;
      if (obs_a.size() != rd_a || valid_a !== 1'b0) begin
         failures++;
         $display("[TB] FAIL false_start: got %0d words valid=%b expected 0 words valid=0",
                  obs_a.size() - rd_a, valid_a);
      end
      // Bit 3 of 0xFF carries a one-clock low spike on the first of its three samples.
      exp_a.push_back({8'hFF, 1'b0, 1'b0});
      hold(0, 1'b0, 16);
      for (int i = 0; i < 3; i++) hold(0, 1'b1, 16);
      hold(0, 1'b1, 8);
      hold(0, 1'b0, 1);
      hold(0, 1'b1, 7);
      for (int i = 4; i < 8; i++) hold(0, 1'b1, 16);
      hold(0, 1'b1, 32);
      e = exp_a.pop_front();
      checks++;
      if (rd_a >= obs_a.size()) begin
         failures++;
         $display("[TB] FAIL glitch_word: got none expected %h", e);
      end else begin
         o = obs_a[rd_a];
         rd_a++;
         if (o !== e) begin
            failures++;
            $display("[TB] FAIL glitch_word: got %h expected %h", o, e);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      word_t e, o;
      ready_a = 1'b0;
      send_frame(0, 8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      hold(0, 1'b0, 16);
      hold(0, 1'b1, 16);
      hold(0, 1'b0, 8);
      rst_n = 1'b0;
      rx_a = 1'b1;
      #1;
      checks++;
      if ({data_a, valid_a, fe_a, pe_a, ovr_a} !== 12'h000) begin
         failures++;
         $display("[TB] FAIL reset_mid: got %h expected 000", {data_a, valid_a, fe_a, pe_a, ovr_a});
      end
      ready_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold(0, 1'b1, 32);
      exp_a.push_back({8'h5A, 1'b0, 1'b0});
      send_frame(0, 8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      repeat (8) @(posedge clk);
      #1;
      e = exp_a.pop_front();
      checks++;
      if (obs_a.size() - rd_a != 1) begin
         failures++;
         $display("[TB] FAIL after_reset_word: got %0d words expected 1 (%h)", obs_a.size() - rd_a, e);
      end else begin
         o = obs_a[rd_a];
         rd_a++;
         if (o !== e) begin
            failures++;
            $display("[TB] FAIL after_reset_word: got %h expected %h", o, e);
         end
      end
   endtask

   task automatic test_break();
      int    base;
      word_t e, o;
      base = brk_cnt_a;
      hold(0, 1'b0, 16 * 20);
      hold(0, 1'b1, 48);
`ifdef UART_RX_CFG_BREAK_EN
      checks++;
      if (brk_cnt_a - base != 1) begin
         failures++;
         $display("[TB] FAIL break_pulse: got %0d cycles expected 1", brk_cnt_a - base);
      end
      checks++;
      if (obs_a.size() != rd_a) begin
         failures++;
         $display("[TB] FAIL break_no_data: got %0d words expected 0", obs_a.size() - rd_a);
      end
`else
      exp_a.push_back({8'h00, 1'b1, 1'b0});
      checks++;
      if (brk_cnt_a != base || obs_a.size() - rd_a != 1) begin
         failures++;
         $display("[TB] FAIL break_frame_count: got %0d words expected 1", obs_a.size() - rd_a);
      end
      e = exp_a.pop_front();
      checks++;
      if (rd_a >= obs_a.size()) begin
         failures++;
         $display("[TB] FAIL break_frame_word: got none expected %h", e);
      end else begin
         o = obs_a[rd_a];
         rd_a = obs_a.size();
         if (o !== e) begin
            failures++;
            $display("[TB] FAIL break_frame_word: got %h expected %h", o, e);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_stop_bits();
      test_overrun();
      test_glitch();
      test_reset_mid_frame();
      test_break();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
